// File: rtl/kf8237_transfer_sequencer_pkg.sv
// Shared types for the KF8237 transfer sequencer: the state enumeration, the
// mode/type encodings, the bus-strobe bundle and the one-hot-to-index helper.
package kf8237_transfer_sequencer_pkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    SW = 3'd5,
    S4 = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    MODE_DEMAND  = 2'b00,
    MODE_SINGLE  = 2'b01,
    MODE_BLOCK   = 2'b10,
    MODE_CASCADE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    TYPE_VERIFY = 2'b00,
    TYPE_WRITE  = 2'b01,
    TYPE_READ   = 2'b10
  } type_e;

  typedef struct packed {
    logic       address_enable;
    logic       address_strobe;
    logic [3:0] dack;
    logic       memory_read_n;
    logic       memory_write_n;
    logic       io_read_n;
    logic       io_write_n;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    address_enable: 1'b0,
    address_strobe: 1'b0,
    dack:           4'b0000,
    memory_read_n:  1'b1,
    memory_write_n: 1'b1,
    io_read_n:      1'b1,
    io_write_n:     1'b1
  };

  function automatic logic [1:0] onehot_to_index(input logic [3:0] onehot);
    logic [1:0] index;
    index = 2'd0;
    if (onehot[3])      index = 2'd3;
    else if (onehot[2]) index = 2'd2;
    else if (onehot[1]) index = 2'd1;
    return index;
  endfunction

endpackage

// File: rtl/kf8237_transfer_sequencer.sv
// KF8237 DMA transfer sequencer: HRQ/HLDA handshake, S1..S4 bus cycle, DACK and strobes.
// Optional build macro KF8237_EXTENDED_WRITE_EN starts the write strobe in S2 instead of S3.
module kf8237_transfer_sequencer
  import kf8237_transfer_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  input  logic [3:0] encoded_dma,
  input  logic [3:0] dma_request_state,
  input  logic [1:0] transfer_mode,
  input  logic [1:0] transfer_type,
  input  logic       hold_acknowledge,
  input  logic       ready,
  input  logic       terminal_count,
  input  logic       end_of_process_n,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge_internal,
  output logic       end_of_process_internal,
  output logic       address_enable,
  output logic       address_strobe,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       next_word,
  output logic [1:0] dma_rotate
);

  state_e     state;
  state_e     next_state;
  logic [3:0] channel;
  mode_e      mode_q;
  type_e      type_q;
  logic       eop_seen;
  bus_t       bus_q;
  bus_t       bus_next;
  logic       advance;
  logic       eop_hit;
  logic       channel_dreq;
  logic       read_phase;
  logic       write_phase;

  assign channel_dreq = |(dma_request_state & channel);
  assign eop_hit      = terminal_count | eop_seen | ~end_of_process_n;
  assign advance      = cpu_clock_posedge & (state == S4);

  assign next_word               = advance;
  assign end_of_process_internal = advance & eop_hit;
  assign hold_request            = (state != SI);

  assign read_phase = state inside {S2, S3, SW};
`ifdef KF8237_EXTENDED_WRITE_EN
  assign write_phase = state inside {S2, S3, SW};
`else
  assign write_phase = state inside {S3, SW};
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      SI: if (encoded_dma != 4'b0000) next_state = S0;
      S0: begin
        if (hold_acknowledge)            next_state = S1;
        else if (encoded_dma == 4'b0000) next_state = SI;
      end
      S1: begin
        if (mode_q != MODE_CASCADE) next_state = S2;
        else if (!channel_dreq)     next_state = SI;
      end
      S2: next_state = S3;
      S3: next_state = ready ? S4 : SW;
      SW: if (ready) next_state = S4;
      S4: begin
        // Termination outranks continuation; block mode only stops on EOP/TC or lost HLDA.
        if (eop_hit || !hold_acknowledge || mode_q == MODE_SINGLE ||
            (mode_q == MODE_DEMAND && !channel_dreq))
          next_state = SI;
        else
          next_state = S2;
      end
      default: next_state = SI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset is active-high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= SI;
      channel    <= 4'b0000;
      mode_q     <= MODE_DEMAND;
      type_q     <= TYPE_VERIFY;
      dma_rotate <= 2'b11;
    end else if (cpu_clock_posedge) begin
      state <= next_state;
      if (state == SI && encoded_dma != 4'b0000) begin
        channel <= encoded_dma;
        mode_q  <= mode_e'(transfer_mode);
        type_q  <= type_e'(transfer_type);
      end
      if (state == S4) dma_rotate <= onehot_to_index(channel);
    end
  end

  // External EOP is remembered from S2 onward and consumed when S4 completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      eop_seen <= 1'b0;
    else if (advance || state == SI)
      eop_seen <= 1'b0;
    else if (!end_of_process_n && (state inside {S2, S3, SW, S4}))
      eop_seen <= 1'b1;
  end

  always_comb begin
    bus_next = BUS_IDLE;
    if (mode_q == MODE_CASCADE) begin
      if (state == S1) bus_next.dack = channel;
    end else if (state != SI && state != S0) begin
      bus_next.address_enable = 1'b1;
      bus_next.address_strobe = (state == S1);
      if (state != S1) bus_next.dack = channel;
      case (type_q)
        TYPE_READ: begin
          bus_next.memory_read_n = ~read_phase;
          bus_next.io_write_n    = ~write_phase;
        end
        TYPE_WRITE: begin
          bus_next.io_read_n      = ~read_phase;
          bus_next.memory_write_n = ~write_phase;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs follow the state half a CPU clock later, on the CPU falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  bus_q <= BUS_IDLE;
    else if (cpu_clock_negedge) bus_q <= bus_next;
  end

  assign address_enable           = bus_q.address_enable;
  assign address_strobe           = bus_q.address_strobe;
  assign dma_acknowledge_internal = bus_q.dack;
  assign memory_read_n            = bus_q.memory_read_n;
  assign memory_write_n           = bus_q.memory_write_n;
  assign io_read_n                = bus_q.io_read_n;
  assign io_write_n               = bus_q.io_write_n;

endmodule

// File: tb/tb_kf8237_transfer_sequencer.sv
// Bench for kf8237_transfer_sequencer: directed vector table, hand sequences and
// randomized transfers checked cycle by cycle against a transfer-level model.
module tb_kf8237_transfer_sequencer;
  import kf8237_transfer_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_clock_posedge, cpu_clock_negedge;
  logic [3:0] encoded_dma, dma_request_state;
  logic [1:0] transfer_mode, transfer_type;
  logic       hold_acknowledge, ready, terminal_count, end_of_process_n;
  logic       hold_request;
  logic [3:0] dma_acknowledge_internal;
  logic       end_of_process_internal, address_enable, address_strobe;
  logic       memory_read_n, memory_write_n, io_read_n, io_write_n;
  logic       next_word;
  logic [1:0] dma_rotate;

  kf8237_transfer_sequencer dut (
    .clock(clock), .reset(reset),
    .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
    .encoded_dma(encoded_dma), .dma_request_state(dma_request_state),
    .transfer_mode(transfer_mode), .transfer_type(transfer_type),
    .hold_acknowledge(hold_acknowledge), .ready(ready),
    .terminal_count(terminal_count), .end_of_process_n(end_of_process_n),
    .hold_request(hold_request), .dma_acknowledge_internal(dma_acknowledge_internal),
    .end_of_process_internal(end_of_process_internal),
    .address_enable(address_enable), .address_strobe(address_strobe),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .io_read_n(io_read_n), .io_write_n(io_write_n),
    .next_word(next_word), .dma_rotate(dma_rotate)
  );

  always #5 clock = ~clock;

`ifdef KF8237_EXTENDED_WRITE_EN
  localparam state_e WR_FIRST = S2;
`else
  localparam state_e WR_FIRST = S3;
`endif
  localparam logic [10:0] BUS_IDLE_VEC = 11'b000_0000_1111;

  // One CPU clock of stimulus plus what the model expects to see during it.
  typedef struct {
    state_e     st;
    logic [3:0] enc, dreq;
    logic       hlda, rdy, tc, eop_n, nw, eop;
  } cyc_t;

  // Transfer scenario (inputs) plus hand-derived expected pulse counts.
  typedef struct {
    int         ch;
    logic [1:0] mode, ttype;
    int         hlda_delay, waits, tc_word, eop_word, drop_word, hdrop_word, casc_len;
    bit         abort;
    int         exp_nw, exp_eop;
  } vec_t;

  int         n_cmp = 0, n_fail = 0;
  cyc_t       model_q[$];
  state_e     obs_st[$];
  logic [10:0] obs_bus[$];
  logic [1:0] exp_rot = 2'b11;
  vec_t       tab[9];
  state_e     req034[8] = '{SI, S0, S0, S1, S2, S3, S4, SI};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int ch, int mode, int ttype, int hd, int waits, int tc, int eop,
                              int drop, int hdrop, int casc, int abort, int nw, int neop);
    vec_t v;
    v.ch = ch; v.mode = 2'(mode); v.ttype = 2'(ttype); v.hlda_delay = hd; v.waits = waits;
    v.tc_word = tc; v.eop_word = eop; v.drop_word = drop; v.hdrop_word = hdrop;
    v.casc_len = casc; v.abort = (abort != 0); v.exp_nw = nw; v.exp_eop = neop;
    return v;
  endfunction

  // Bus picture expected for a state: {hrq, aen, adstb, dack, mr_n, mw_n, ior_n, iow_n}.
  function automatic logic [10:0] exp_bus(state_e st, logic [3:0] oh, logic [1:0] mode, logic [1:0] ttype);
    logic hrq, aen, adstb, mr, mw, ior, iow, rd, wr;
    logic [3:0] dack;
    hrq = (st != SI); aen = 1'b0; adstb = 1'b0; dack = 4'b0;
    mr = 1'b1; mw = 1'b1; ior = 1'b1; iow = 1'b1;
    rd = (st == S2 || st == S3 || st == SW);
    wr = (st == S3 || st == SW || (WR_FIRST == S2 && st == S2));
    if (mode == 2'b11) begin
      if (st == S1) dack = oh;
    end else if (st != SI && st != S0) begin
      aen = 1'b1; adstb = (st == S1);
      if (st != S1) dack = oh;
      if (ttype == 2'b10) begin mr = ~rd; iow = ~wr; end
      if (ttype == 2'b01) begin ior = ~rd; mw = ~wr; end
    end
    return {hrq, aen, adstb, dack, mr, mw, ior, iow};
  endfunction

  function automatic void push(state_e st, logic [3:0] enc, logic [3:0] dreq, logic hlda,
                               logic rdy, logic tc, logic eop_n, logic nw, logic eop);
    cyc_t c;
    c.st = st; c.enc = enc; c.dreq = dreq; c.hlda = hlda; c.rdy = rdy;
    c.tc = tc; c.eop_n = eop_n; c.nw = nw; c.eop = eop;
    model_q.push_back(c);
  endfunction

  // Expand a scenario into the CPU-clock sequence the transfer rules imply.
  task automatic build_model(input vec_t v);
    logic [3:0] oh, noise, dq;
    logic       hl;
    oh = 4'b0001 << v.ch;
    noise = 4'($urandom) & ~oh;
    model_q.delete();
    push(SI, oh, oh | noise, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if (v.abort) begin
      push(S0, 4'b0, noise, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      push(SI, 4'b0, noise, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      return;
    end
    for (int i = 1; i <= v.hlda_delay; i++)
      push(S0, oh, oh | noise, i == v.hlda_delay, 1'b1, 1'b0, $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    if (v.mode == 2'b11) begin
      for (int i = 1; i <= v.casc_len; i++)
        push(S1, 4'b0, (i == v.casc_len) ? noise : (oh | noise), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      push(SI, 4'b0, noise, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      return;
    end
    push(S1, 4'b0, oh | noise, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    dq = oh | noise;
    hl = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      bit tc, ep, drop, stop_dreq, hd;
      int wt;
      tc = (w == v.tc_word); ep = (w == v.eop_word); drop = (w == v.drop_word);
      stop_dreq = drop && (v.mode == 2'b00); hd = (w == v.hdrop_word);
      wt = (w == 1) ? v.waits : 0;
      push(S2, 4'b0, dq, hl, 1'b1, 1'($urandom), ~ep, 1'b0, 1'b0);
      if (drop) dq = noise;
      if (hd) hl = 1'b0;
      push(S3, 4'b0, dq, hl, wt == 0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 1; j <= wt; j++) push(SW, 4'b0, dq, hl, j == wt, 1'b0, 1'b1, 1'b0, 1'b0);
      push(S4, 4'b0, dq, hl, 1'b1, tc, 1'b1, 1'b1, tc || ep);
      if (tc || ep || v.mode == 2'b01 || stop_dreq || hd) break;
    end
    push(SI, 4'b0, noise, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // One CPU clock = four system clocks: falling strobe on the 2nd, rising strobe on the 4th.
  task automatic run_cycle(input cyc_t c, output state_e st, output logic [10:0] bus,
                           output int nw, output int ep);
    encoded_dma = c.enc; dma_request_state = c.dreq; hold_acknowledge = c.hlda;
    ready = c.rdy; terminal_count = c.tc; end_of_process_n = c.eop_n;
    nw = 0; ep = 0; st = SI; bus = '0;
    for (int k = 0; k < 4; k++) begin
      cpu_clock_negedge = (k == 1);
      cpu_clock_posedge = (k == 3);
      @(negedge clock);
      if (k == 2) begin
        st  = dut.state;
        bus = {hold_request, address_enable, address_strobe, dma_acknowledge_internal,
               memory_read_n, memory_write_n, io_read_n, io_write_n};
      end
      nw += int'(next_word);
      ep += int'(end_of_process_internal);
      @(posedge clock); #1;
    end
    cpu_clock_negedge = 1'b0;
    cpu_clock_posedge = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, output int nw_tot, output int eop_tot);
    state_e st;
    logic [10:0] bus;
    int nw, ep;
    logic [3:0] oh;
    oh = 4'b0001 << v.ch;
    transfer_mode = v.mode; transfer_type = v.ttype;
    build_model(v);
    obs_st.delete(); obs_bus.delete();
    nw_tot = 0; eop_tot = 0;
    foreach (model_q[i]) begin
      run_cycle(model_q[i], st, bus, nw, ep);
      obs_st.push_back(st); obs_bus.push_back(bus);
      check($sformatf("state[%0d]", i), 32'(st), 32'(model_q[i].st));
      check($sformatf("bus[%0d] in %s", i, model_q[i].st.name()), 32'(bus),
            32'(exp_bus(model_q[i].st, oh, v.mode, v.ttype)));
      check($sformatf("next_word[%0d]", i), 32'(nw), 32'(model_q[i].nw));
      check($sformatf("eop_pulse[%0d]", i), 32'(ep), 32'(model_q[i].eop));
      nw_tot += nw; eop_tot += ep;
      if (model_q[i].nw) exp_rot = 2'(v.ch);
    end
    check("dma_rotate", 32'(dma_rotate), 32'(exp_rot));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, ep, first, cnt;
    state_e st;
    logic [10:0] bus;
    vec_t v;

    tab[0] = mk(2, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0); // ch2 single read, HLDA after 2
    tab[1] = mk(0, 2, 1, 1, 0, 3, 0, 0, 0, 0, 0, 3, 1); // ch0 block write, TC on word 3
    tab[2] = mk(1, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0); // two wait states
    tab[3] = mk(1, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 2, 0); // demand, DREQ drops in word 2
    tab[4] = mk(3, 2, 2, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1); // external EOP in S2
    tab[5] = mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0); // cascade, 3 CPU clocks
    tab[6] = mk(1, 2, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0); // request withdrawn before HLDA
    tab[7] = mk(2, 2, 1, 2, 1, 0, 0, 1, 2, 0, 0, 2, 0); // block ignores DREQ, HLDA lost in word 2
    tab[8] = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); // verify: no strobes

    reset = 1'b1;
    cpu_clock_posedge = 1'b0; cpu_clock_negedge = 1'b0;
    encoded_dma = 4'b0; dma_request_state = 4'b0; transfer_mode = 2'b0; transfer_type = 2'b0;
    hold_acknowledge = 1'b0; ready = 1'b1; terminal_count = 1'b0; end_of_process_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_bus", 32'({hold_request, address_enable, address_strobe, dma_acknowledge_internal,
                            memory_read_n, memory_write_n, io_read_n, io_write_n}), 32'(BUS_IDLE_VEC));
    check("reset_pulses_rotate", 32'({next_word, end_of_process_internal, dma_rotate}), 32'b0011);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) begin
      run_vec(tab[i], nw, ep);
      check($sformatf("tab%0d_next_words", i), 32'(nw), 32'(tab[i].exp_nw));
      check($sformatf("tab%0d_eop_pulses", i), 32'(ep), 32'(tab[i].exp_eop));
    end

    // Exact state walk of a single read with HLDA after two CPU clocks.
    run_vec(tab[0], nw, ep);
    for (int i = 0; i < 8; i++)
      check($sformatf("walk034[%0d]", i), 32'(obs_st[i]), 32'(req034[i]));

    // Which state the write strobe (IOW# on a read transfer) first falls in.
    first = -1;
    foreach (obs_bus[i]) if (first < 0 && obs_bus[i][0] == 1'b0) first = i;
    check("write_strobe_first_state", (first >= 0) ? 32'(obs_st[first]) : 32'hff, 32'(WR_FIRST));

    for (int r = 0; r < 30; r++) begin
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 3),
             $urandom_range(0, 2), $urandom_range(0, 3), 0, $urandom_range(1, 3), 0,
             $urandom_range(1, 3), ($urandom_range(0, 9) == 0) ? 1 : 0, 0, 0);
      if ($urandom_range(0, 2) == 0) v.eop_word = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) v.hdrop_word = $urandom_range(1, 3);
      if (v.mode == 2'b10 && v.tc_word == 0 && v.eop_word == 0 && v.hdrop_word == 0) v.tc_word = 3;
      run_vec(v, nw, ep);
    end

    // Reset in the middle of S3 of a block read: immediate abort, no pulses.
    v = mk(1, 2, 2, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    transfer_mode = v.mode; transfer_type = v.ttype;
    build_model(v);
    for (int i = 0; i < 4; i++) run_cycle(model_q[i], st, bus, nw, ep);
    encoded_dma = 4'b0; hold_acknowledge = 1'b1; ready = 1'b1;
    cpu_clock_negedge = 1'b1;
    @(posedge clock); #1;
    cpu_clock_negedge = 1'b0;
    check("pre_reset_memory_read_n", 32'(memory_read_n), 32'd0);
    reset = 1'b1; terminal_count = 1'b1;
    #1;
    check("abort_state", 32'(dut.state), 32'(SI));
    check("abort_bus", 32'({hold_request, address_enable, address_strobe, dma_acknowledge_internal,
                            memory_read_n, memory_write_n, io_read_n, io_write_n}), 32'(BUS_IDLE_VEC));
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cpu_clock_negedge = (k % 4 == 1);
      cpu_clock_posedge = (k % 4 == 3);
      @(negedge clock);
      cnt += int'(next_word) + int'(end_of_process_internal);
      @(posedge clock); #1;
    end
    cpu_clock_negedge = 1'b0; cpu_clock_posedge = 1'b0; terminal_count = 1'b0;
    check("abort_pulses", 32'(cnt), 32'd0);
    check("abort_rotate", 32'(dma_rotate), 32'd3);
    reset = 1'b0;
    @(posedge clock); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/kf8237_transfer_sequencer.md
KF8237_TRANSFER_SEQUENCER -- requirements
Module: kf8237_transfer_sequencer

Interface
REQ-001 Parameters: none.
REQ-002 clock  in  1  system clock; reset  in  1  reset, asynchronous, active-high.
REQ-003 cpu_clock_posedge / cpu_clock_negedge  in  1 each  single-cycle CPU-clock edge strobes.
REQ-004 encoded_dma  in  4  one-hot winning channel from the priority encoder; 0 means no request.
REQ-005 dma_request_state  in  4  live masked requests, used for demand-mode continuation.
REQ-006 transfer_mode  in  2  mode of the granted channel: 00 demand, 01 single, 10 block, 11 cascade.
REQ-007 transfer_type  in  2  type of the granted channel: 00 verify, 01 write (IO->mem), 10 read (mem->IO).
REQ-008 hold_acknowledge  in  1  HLDA; ready  in  1  READY; terminal_count  in  1  count underflow of the current channel.
REQ-009 end_of_process_n  in  1  external EOP#, active-low.
REQ-010 hold_request  out  1  HRQ; dma_acknowledge_internal  out  4  one-hot DACK of the active channel.
REQ-011 end_of_process_internal  out  1  one-clock pulse on transfer termination.
REQ-012 address_enable / address_strobe  out  1 each  AEN / ADSTB.
REQ-013 memory_read_n, memory_write_n, io_read_n, io_write_n  out  1 each  bus strobes, active-low.
REQ-014 next_word  out  1  one-clock pulse: the address/count block advances.
REQ-015 dma_rotate  out  2  index of the last serviced channel, fed back to the priority encoder.

Function
REQ-016 States: SI (idle), S0 (HRQ, wait HLDA), S1, S2, S3, SW (wait), S4; transitions only on cycles where cpu_clock_posedge=1.
REQ-017 SI: encoded_dma!=0 -> latch channel, hold_request=1, go to S0.
REQ-018 S0: hold_acknowledge=1 -> S1; encoded_dma=0 before HLDA -> drop HRQ, go to SI.
REQ-019 S1: address_enable=1, address_strobe=1 for this state only; go to S2.
REQ-020 S2: assert DACK; assert read strobe (memory_read_n for read, io_read_n for write); go to S3; verify type asserts no strobes.
REQ-021 S3: assert write strobe (io_write_n for read, memory_write_n for write); ready=0 -> SW, else S4.
REQ-022 SW: hold all strobes; ready=1 -> S4.
REQ-023 S4: deassert strobes; pulse next_word once; dma_rotate <= channel index.
REQ-024 After S4: end_of_process_internal=1, or single mode, or demand mode with the DREQ bit of the channel cleared -> release HRQ/AEN/DACK and go to SI; otherwise go to S2 (block mode reuses the address, no S1 unless the low address byte wraps, signalled by terminal_count unaffected).
REQ-025 end_of_process_internal pulses when terminal_count=1 in S4 or end_of_process_n=0 sampled during S2..S4; EOP has priority over continuation.
REQ-026 Cascade mode: after HLDA, assert DACK only and stay in S1-equivalent state until the channel DREQ drops; no strobes, no AEN.
REQ-027 hold_acknowledge dropping mid-transfer -> finish the current S4, then go to SI.
REQ-028 Strobes and DACK change only on cpu_clock_negedge-aligned cycles following the state change, giving a half CPU clock of setup.

Reset
REQ-029 Reset state SI; outputs 0, except the *_n strobes, which are 1, and dma_rotate=2'b11.
REQ-030 Reset mid-transfer aborts immediately; no next_word or end_of_process_internal pulse.

Configuration
REQ-031 KF8237_EXTENDED_WRITE_EN defined: the write strobe asserts in S2 together with the read strobe; undefined: the write strobe asserts in S3 only.

Structure
REQ-032 A shared package holds the state enumeration, the transfer_mode and transfer_type encodings, and the one-hot-to-index function.
REQ-033 The block is a single module with no sub-modules.

Verification
REQ-034 Ch2 single read, HLDA after 2 clocks, ready=1 -> S0,S0,S1,S2,S3,S4,SI; one next_word; dma_rotate=2.
REQ-035 Ch0 block write with terminal_count after 3 words -> S1 once, S2-S4 x3, one EOP pulse, then SI.
REQ-036 ready=0 for 2 CPU clocks in S3 -> two SW states, strobes held low, then S4.
REQ-037 Demand ch1: DREQ drops during the 2nd word -> exit after that S4, no EOP pulse.
REQ-038 end_of_process_n=0 in S2 -> EOP pulse in S4, DACK released.
REQ-039 Run with KF8237_EXTENDED_WRITE_EN defined and undefined -> write strobe first falls in S2 and in S3 respectively.
